hls_ctrl_initiator: RTL and testbench

//  Initiator side of the ap_ctrl_hs block-level handshake. Sits between a job

---
 rtl/hls_ctrl_pkg.sv | 17 +
 rtl/hls_ctrl_watchdog.sv | 29 ++
 rtl/hls_ctrl_initiator.sv | 181 ++++++++++++++++++
 tb/tb_hls_ctrl_initiator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hls_ctrl_pkg.sv
// Shared definitions for the HLS ap_ctrl_hs initiator: FSM state encoding and
// response status codes (also used by the key-loader and the testbench).
package hls_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RECOVER = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_NO_VLD  = 2'b10;

endpackage

// File: rtl/hls_ctrl_watchdog.sv
// Loadable down-counter that stops at zero. One instance serves both the job
// timeout window and the core reset hold time.
module hls_ctrl_watchdog #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count;

  // A load takes priority over the decrement issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/hls_ctrl_initiator.sv
// Initiator for the ap_ctrl_hs handshake: launches one job on a locked HLS core,
// collects its result and recovers a hung core by timeout and reset.
module hls_ctrl_initiator
  import hls_ctrl_pkg::*;
#(
  parameter int ARG_W       = 128,
  parameter int RES_W       = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RST_CYC     = 4,
  parameter int CNT_W       = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ARG_W-1:0] req_args,
  output logic             core_start,
  output logic [ARG_W-1:0] core_args,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic             core_idle,
  input  logic [RES_W-1:0] core_res,
  input  logic             core_res_vld,
  output logic             core_rst,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic [1:0]       rsp_status,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_fail
);

  localparam int WD_MAX = (TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC;
  localparam int WD_W   = $clog2(WD_MAX) + 1;

  state_t            state, state_next;
  logic [RES_W-1:0]  res_reg;
  logic              vld_flag;
  logic              accept;
  logic              done_hit;
  logic              timeout_hit;
  logic              rsp_take;
  logic              wd_load;
  logic [WD_W-1:0]   wd_load_val;
  logic              wd_dec;
  logic              wd_expired;

  hls_ctrl_watchdog #(.W(WD_W)) u_watchdog (
    .clk      (ap_clk),
    .rst      (ap_rst),
    .load     (wd_load),
    .load_val (wd_load_val),
    .dec      (wd_dec),
    .expired  (wd_expired)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Completion by core_done is tested before watchdog expiry so a done that
  // lands on the last allowed cycle still counts as a normal finish.
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    core_start  = 1'b0;
    core_rst    = 1'b0;
    rsp_valid   = 1'b0;
    accept      = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    rsp_take    = 1'b0;
    wd_load     = 1'b0;
    wd_load_val = '0;
    wd_dec      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = core_idle;
        if (req_valid && core_idle) begin
          accept      = 1'b1;
          wd_load     = 1'b1;
          wd_load_val = WD_W'(TIMEOUT_CYC - 1);
          state_next  = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        wd_dec     = 1'b1;
        if (core_ready && core_done) begin
          done_hit   = 1'b1;
          state_next = S_RESP;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          wd_load     = 1'b1;
          wd_load_val = WD_W'(RST_CYC - 1);
          state_next  = S_RECOVER;
        end else if (core_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_dec = 1'b1;
        if (core_done) begin
          done_hit   = 1'b1;
          state_next = S_RESP;
        end else if (wd_expired) begin
          timeout_hit = 1'b1;
          wd_load     = 1'b1;
          wd_load_val = WD_W'(RST_CYC - 1);
          state_next  = S_RECOVER;
        end
      end
      S_RECOVER: begin
        core_rst = 1'b1;
        wd_dec   = 1'b1;
        if (wd_expired) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_take   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A result strobe coincident with core_done is folded straight into the response.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      core_args  <= '0;
      res_reg    <= '0;
      vld_flag   <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
      cnt_ok     <= '0;
      cnt_fail   <= '0;
    end else begin
      if (accept) begin
        core_args <= req_args;
        res_reg   <= '0;
        vld_flag  <= 1'b0;
      end
      if (((state == S_START) || (state == S_WAIT)) && core_res_vld) begin
        res_reg  <= core_res;
        vld_flag <= 1'b1;
      end
      if (done_hit) begin
        if (core_res_vld) begin
          rsp_status <= ST_OK;
          rsp_data   <= core_res;
        end else if (vld_flag) begin
          rsp_status <= ST_OK;
          rsp_data   <= res_reg;
        end else begin
          rsp_status <= ST_NO_VLD;
          rsp_data   <= '0;
        end
      end
      if (timeout_hit) begin
        rsp_status <= ST_TIMEOUT;
        rsp_data   <= '0;
      end
      if (rsp_take) begin
        if (rsp_status == ST_OK) begin
          if (cnt_ok != '1) cnt_ok <= cnt_ok + 1'b1;
        end else begin
          if (cnt_fail != '1) cnt_fail <= cnt_fail + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hls_ctrl_initiator.sv
// Self-checking bench for hls_ctrl_initiator: table of core behaviours plus
// hand-written reset, idle-gating and backpressure sequences.
module tb_hls_ctrl_initiator;
  import hls_ctrl_pkg::*;

  localparam int ARG_W       = 128;
  localparam int RES_W       = 32;
  localparam int TIMEOUT_CYC = 16;
  localparam int RST_CYC     = 4;
  localparam int CNT_W       = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic             req_valid;
  logic             req_ready;
  logic [ARG_W-1:0] req_args;
  logic             core_start;
  logic [ARG_W-1:0] core_args;
  logic             core_ready;
  logic             core_done;
  logic             core_idle;
  logic [RES_W-1:0] core_res;
  logic             core_res_vld;
  logic             core_rst;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_data;
  logic [1:0]       rsp_status;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_fail;

  hls_ctrl_initiator #(
    .ARG_W(ARG_W), .RES_W(RES_W), .TIMEOUT_CYC(TIMEOUT_CYC),
    .RST_CYC(RST_CYC), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_args(req_args),
    .core_start(core_start), .core_args(core_args),
    .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
    .core_res(core_res), .core_res_vld(core_res_vld), .core_rst(core_rst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .cnt_ok(cnt_ok), .cnt_fail(cnt_fail)
  );

  always #5 ap_clk = ~ap_clk;

  // Event times are cycles after the first core_start cycle; -1 means never.
  typedef struct {
    string            name;
    int               ready_at;
    int               done_at;
    int               vld_at;
    int               vld2_at;
    logic [RES_W-1:0] res;
    logic [RES_W-1:0] res2;
    int               rsp_wait;
    logic [1:0]       exp_status;
    logic [RES_W-1:0] exp_data;
    int               exp_start;
    int               exp_rst;
  } vec_t;

  typedef struct {
    logic [1:0]       status;
    logic [RES_W-1:0] data;
  } rsp_t;

  vec_t vecs[9];
  rsp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   model_ok = 0;
  int   model_fail = 0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [ARG_W-1:0] args;
    rsp_t exp;
    int   c;
    int   starts;
    int   rsts;
    bit   got;
    args = {$urandom, $urandom, $urandom, $urandom};
    exp.status = v.exp_status;
    exp.data   = v.exp_data;
    sb_q.push_back(exp);
    check_output({v.name, " req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_args  = args;
    @(negedge ap_clk);
    req_valid = 1'b0;
    req_args  = '0;
    c = 0; starts = 0; rsts = 0; got = 0;
    while (!got && c < 200) begin
      if (rsp_valid) begin
        got = 1;
      end else begin
        if (core_start) starts++;
        if (core_rst) rsts++;
        check_output({v.name, " core_args"}, core_args, args);
        check_output({v.name, " req_ready_busy"}, req_ready, 0);
        core_ready   = (c == v.ready_at);
        core_done    = (c == v.done_at);
        core_res_vld = (c == v.vld_at) || (c == v.vld2_at);
        core_res     = (c == v.vld2_at) ? v.res2 : ((c == v.vld_at) ? v.res : $urandom);
        @(negedge ap_clk);
        c++;
      end
    end
    core_ready = 1'b0; core_done = 1'b0; core_res_vld = 1'b0;
    if (!got) begin
      checks++;
      $display("[TB] FAIL %s rsp_wait_bound: rsp_valid not seen in 200 cycles", v.name);
      void'(sb_q.pop_front());
      return;
    end
    check_output({v.name, " start_cycles"}, starts, v.exp_start);
    check_output({v.name, " rst_cycles"}, rsts, v.exp_rst);
    for (int i = 0; i < v.rsp_wait; i++) begin
      check_output({v.name, " hold_status"}, rsp_status, sb_q[0].status);
      check_output({v.name, " hold_data"}, rsp_data, sb_q[0].data);
      check_output({v.name, " hold_req_ready"}, req_ready, 0);
      check_output({v.name, " hold_valid"}, rsp_valid, 1);
      @(negedge ap_clk);
    end
    rsp_ready = 1'b1;
    exp = sb_q.pop_front();
    check_output({v.name, " rsp_status"}, rsp_status, exp.status);
    check_output({v.name, " rsp_data"}, rsp_data, exp.data);
    check_output({v.name, " rsp_args"}, core_args, args);
    if (exp.status == ST_OK) model_ok++;
    else model_fail++;
    @(negedge ap_clk);
    rsp_ready = 1'b0;
    check_output({v.name, " req_ready_after"}, req_ready, 1);
    check_output({v.name, " rsp_valid_after"}, rsp_valid, 0);
    check_output({v.name, " cnt_ok"}, cnt_ok, model_ok);
    check_output({v.name, " cnt_fail"}, cnt_fail, model_fail);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " req_ready"}, req_ready, 1);
    check_output({tag, " core_start"}, core_start, 0);
    check_output({tag, " core_rst"}, core_rst, 0);
    check_output({tag, " core_args"}, core_args, 0);
    check_output({tag, " rsp_valid"}, rsp_valid, 0);
    check_output({tag, " rsp_data"}, rsp_data, 0);
    check_output({tag, " rsp_status"}, rsp_status, 0);
    check_output({tag, " cnt_ok"}, cnt_ok, 0);
    check_output({tag, " cnt_fail"}, cnt_fail, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_time_limit: simulation did not finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    vecs[0] = '{"normal",       1,  5,  5, -1, 32'h1234, 32'h0,  0, ST_OK,      32'h1234, 2,  0};
    vecs[1] = '{"single_cycle", 0,  0,  0, -1, 32'hA5,   32'h0,  0, ST_OK,      32'hA5,   1,  0};
    vecs[2] = '{"hung",        -1, -1, -1, -1, 32'h0,    32'h0,  0, ST_TIMEOUT, 32'h0,    16, 4};
    vecs[3] = '{"no_vld",       1,  3, -1, -1, 32'h0,    32'h0,  0, ST_NO_VLD,  32'h0,    2,  0};
    vecs[4] = '{"two_vld",      0,  4,  1,  3, 32'h1,    32'h2,  0, ST_OK,      32'h2,    1,  0};
    vecs[5] = '{"backpressure", 1,  5,  5, -1, 32'hC0DE, 32'h0, 10, ST_OK,      32'hC0DE, 2,  0};
    vecs[6] = '{"hung_vld",     2, -1,  3, -1, 32'h77,   32'h0,  0, ST_TIMEOUT, 32'h0,    3,  4};
    vecs[7] = '{"done_at_edge", 0, 15, 15, -1, 32'hBEEF, 32'h0,  0, ST_OK,      32'hBEEF, 1,  0};
    vecs[8] = '{"start_edge",  15, 15, 15, -1, 32'h5A5A, 32'h0,  0, ST_OK,      32'h5A5A, 16, 0};

    ap_rst = 1'b1; req_valid = 1'b0; req_args = '0;
    core_ready = 1'b0; core_done = 1'b0; core_idle = 1'b1;
    core_res = '0; core_res_vld = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    check_reset_outputs("por");
    ap_rst = 1'b0;
    @(negedge ap_clk);

    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

    // Core reports busy: request must not be taken.
    core_idle = 1'b0;
    req_valid = 1'b1;
    req_args  = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check_output("idle_gate req_ready", req_ready, 0);
      check_output("idle_gate core_start", core_start, 0);
    end
    req_valid = 1'b0;
    core_idle = 1'b1;
    @(negedge ap_clk);

    // Reset while the job sits in WAIT drops it silently.
    req_valid = 1'b1;
    req_args  = {4{32'h1357_9BDF}};
    @(negedge ap_clk);
    req_valid  = 1'b0;
    core_ready = 1'b1;
    @(negedge ap_clk);
    core_ready = 1'b0;
    repeat (2) @(negedge ap_clk);
    check_output("mid_rst in_wait core_start", core_start, 0);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    check_reset_outputs("mid_rst");
    model_ok = 0;
    model_fail = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check_output("mid_rst no_rsp", rsp_valid, 0);
      check_output("mid_rst no_core_rst", core_rst, 0);
    end
    apply_stimulus(vecs[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
